// File: rtl/hub75_scan_if.sv
// rtl/hub75_scan_if.sv - scan controller to row shifter handshake
// The scanner drives row/plane select and a start pulse; the shifter reports idle.
interface hub75_scan_if #(
  parameter int LOG_N_ROWS = 5,
  parameter int N_PLANES   = 8
);
  logic [LOG_N_ROWS-1:0] shift_row;
  logic [N_PLANES-1:0]   shift_plane;
  logic                  shift_go;
  logic                  shift_rdy;

  modport master (
    output shift_row,
    output shift_plane,
    output shift_go,
    input  shift_rdy
  );

  modport slave (
    input  shift_row,
    input  shift_plane,
    input  shift_go,
    output shift_rdy
  );
endinterface

// File: rtl/hub75_scan.sv
// rtl/hub75_scan.sv - HUB75 row/bit-plane scan sequencer with BCM display timer
// Shifting of the next plane overlaps the display of the current one.
module hub75_scan #(
  parameter int N_ROWS     = 32,
  parameter int N_PLANES   = 8,
  parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_run,
  input  logic [7:0]            cfg_base_len,
  output logic [LOG_N_ROWS-1:0] hub75_addr,
  output logic                  hub75_le,
  output logic                  hub75_blank,
  output logic                  frame_start,
  hub75_scan_if.master          shift
);
  localparam int PW = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam int TW = 8 + N_PLANES;

  typedef enum logic [2:0] {
    IDLE, GO, SHIFT, FLUSH, DWAIT, BLANK, LATCH, UNBLANK
  } state_t;

  state_t                state_q, state_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic [PW-1:0]         plane_q, plane_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [LOG_N_ROWS-1:0] addr_q, addr_d;

  logic          last_row;
  logic          last_plane;
  logic [7:0]    base_eff;
  logic [TW-1:0] on_time;
  logic          go;

  assign last_row   = (row_q == LOG_N_ROWS'(N_ROWS - 1));
  assign last_plane = (plane_q == PW'(N_PLANES - 1));
  assign base_eff   = (cfg_base_len == 8'd0) ? 8'd1 : cfg_base_len;
  assign on_time    = {{N_PLANES{1'b0}}, base_eff} << plane_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    // The display timer free-runs down to zero regardless of FSM state.
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    case (state_q)
      IDLE: begin
        if (ctrl_run && shift.shift_rdy) begin
          state_d = GO;
          row_d   = '0;
          plane_d = '0;
        end
      end
      GO: begin
        if (shift.shift_rdy) begin
          state_d = SHIFT;
          cnt_d   = 2'd0;
        end
      end
      SHIFT: begin
        // shift_rdy may still read stale-high the cycle right after the go pulse.
        if (cnt_q == 2'd0) begin
          cnt_d = 2'd1;
        end else if (shift.shift_rdy) begin
          state_d = FLUSH;
          cnt_d   = 2'd0;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd3) state_d = DWAIT;
        else               cnt_d   = cnt_q + 2'd1;
      end
      DWAIT: begin
        if (timer_q == '0) begin
          state_d = BLANK;
          cnt_d   = 2'd0;
          addr_d  = row_q;
        end
      end
      BLANK: begin
        if (cnt_q == 2'd1) state_d = LATCH;
        else               cnt_d   = cnt_q + 2'd1;
      end
      LATCH: state_d = UNBLANK;
      UNBLANK: begin
        timer_d = on_time;
        if (last_plane) begin
          plane_d = '0;
          row_d   = last_row ? '0 : row_q + LOG_N_ROWS'(1);
        end else begin
          plane_d = plane_q + PW'(1);
        end
        state_d = (!ctrl_run && last_plane && last_row) ? IDLE : GO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
    end
  end

  assign go                = (state_q == GO) && shift.shift_rdy;
  assign shift.shift_go    = go;
  assign shift.shift_row   = row_q;
  assign shift.shift_plane = N_PLANES'(1) << plane_q;
  assign frame_start       = go && (row_q == '0) && (plane_q == '0);
  assign hub75_addr        = addr_q;
  assign hub75_le          = (state_q == LATCH);
  assign hub75_blank       = (state_q inside {IDLE, BLANK, LATCH, UNBLANK}) || (timer_q == '0);
endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL have parameter N_ROWS, default 32, meaning number of multiplexed rows per bank (power of 2).
REQ-002 SHALL have parameter N_PLANES, default 8, meaning BCM bit planes per colour channel.
REQ-003 SHALL have parameter LOG_N_ROWS, default $clog2(N_ROWS), meaning row address width (auto-set).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ctrl_run  input  1  enables scanning.
REQ-007 SHALL have port cfg_base_len  input  8  LSB-plane on-time in clk cycles.
REQ-008 SHALL have port hub75_addr  output  LOG_N_ROWS  panel row address.
REQ-009 SHALL have port hub75_le  output  1  panel latch enable.
REQ-010 SHALL have port hub75_blank  output  1  panel output disable (1 = dark).
REQ-011 SHALL have port shift_row  output  LOG_N_ROWS  row currently being shifted (framebuffer row select).
REQ-012 SHALL have port shift_plane  output  N_PLANES  one-hot plane select to the shifter.
REQ-013 SHALL have port shift_go  output  1  one-cycle start pulse to the shifter.
REQ-014 SHALL have port shift_rdy  input  1  shifter idle.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse at start of each frame.

Function
REQ-016 SHALL scan rows 0..N_ROWS-1 in order and, for each row, planes 0..N_PLANES-1 in order; after row N_ROWS-1 plane N_PLANES-1, SHALL wrap to row 0 plane 0.
REQ-017 SHALL implement FSM states IDLE, GO, SHIFT, FLUSH, DWAIT, BLANK, LATCH, UNBLANK.
REQ-018 IDLE: hub75_blank=1; when ctrl_run=1 and shift_rdy=1, SHALL go to GO with row 0, plane 0.
REQ-019 GO: shift_go=1 for exactly one cycle, with shift_plane=1<<plane and shift_row=row stable from this cycle until LATCH; next state SHIFT.
REQ-020 SHIFT: SHALL wait for shift_rdy=1 (ignored in the first cycle after GO); next state FLUSH.
REQ-021 FLUSH: SHALL wait 4 cycles to cover the shifter output pipeline tail; next state DWAIT.
REQ-022 DWAIT: SHALL wait until the display timer reaches 0; next state BLANK.
REQ-023 BLANK: hub75_blank=1 for 2 cycles; hub75_addr SHALL update to shift_row on the first BLANK cycle; next state LATCH.
REQ-024 LATCH: hub75_le=1 for exactly one cycle, hub75_blank=1; next state UNBLANK.
REQ-025 UNBLANK: hub75_blank SHALL go 0 the following cycle; the display timer SHALL load max(cfg_base_len,1) << plane (width 8+N_PLANES, no overflow); plane/row SHALL advance; next state GO, or IDLE if ctrl_run=0 and the just-latched plane was row N_ROWS-1 plane N_PLANES-1.
REQ-026 Display timer SHALL decrement by 1 per cycle while nonzero, independently of the FSM, so that shifting of plane p+1 overlaps display of plane p.
REQ-027 When the timer reaches 0 before the FSM reaches BLANK, hub75_blank SHALL go 1 at that cycle (no over-display).
REQ-028 frame_start SHALL pulse for one cycle coincident with shift_go for row 0 plane 0.
REQ-029 cfg_base_len SHALL be sampled only in UNBLANK; changes take effect on the next plane.
REQ-030 ctrl_run deasserted mid-frame SHALL complete the frame, then enter IDLE with hub75_blank=1.
REQ-031 shift_go SHALL never be asserted while shift_rdy=0.

Reset
REQ-032 On rst, SHALL enter IDLE within one cycle with hub75_blank=1, hub75_le=0, hub75_addr=0, shift_row=0, shift_plane=1, shift_go=0, frame_start=0, timer=0.
REQ-033 rst asserted mid-operation SHALL abort immediately to the reset state without emitting hub75_le.

Verification
REQ-034 N_ROWS=4, N_PLANES=2, base=10, shifter model 64-cycle busy, ctrl_run=1 -> shift_go/frame_start pulse together at row 0 plane 0; latch order (r,p)=(0,0),(0,1),(1,0)...(3,1),(0,0).
REQ-035 Same config -> measured hub75_blank=0 spans: 10 cycles for plane 0, 20 cycles for plane 1; exactly one hub75_le per plane.
REQ-036 base=200, N_PLANES=8 -> plane 7 on-time 25600 cycles; FSM waits in DWAIT; no second shift_go until the preceding plane's shift completes.
REQ-037 base=0 -> on-time 1 cycle for plane 0, 2 for plane 1.
REQ-038 ctrl_run dropped at row 2 -> remaining planes through row 3 plane 1 latched, then IDLE, blank=1, no further shift_go.
REQ-039 rst pulsed during SHIFT -> next cycle: blank=1, addr=0, shift_plane=1; hub75_le never high.
